// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the transmit and receive ends.
// Holds the frame state encoding, the default bit period, the line levels of the
// framing bits and a parity helper, so both ends of the link agree on framing.
package uart_pkg;

    // Frame states; the numeric encoding is shared with the receiver.
    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StStart  = 3'd1,
        StData   = 3'd2,
        StParity = 3'd3,
        StStop   = 3'd4
    } uart_state_e;

    // System clocks per serial bit (10 at 50 MHz matches the receiver bench).
    localparam int unsigned DefaultClksPerBit = 10;

    localparam int unsigned DataBits      = 8;
    localparam logic        IdleLevel     = 1'b1;
    localparam logic        StartBitLevel = 1'b0;
    localparam logic        StopBitLevel  = 1'b1;

    // Parity bit for a byte: even parity by default, inverted for odd.
    function automatic logic calc_parity(input logic [DataBits-1:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter shared by the UART transmitter and receiver.
// Counts system clocks 0..CLKS_PER_BIT-1 while enabled and flags the last count.
// Held at zero while disabled so every frame starts on a fresh bit period.
// Ports:
//   clk        - system clock, rising edge
//   rst_n      - synchronous active-low reset
//   en_i       - count enable (high while a frame is in progress)
//   bit_tick_o - high in the final clock of each bit period
module uart_baud_cnt
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DefaultClksPerBit
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    output logic bit_tick_o
);

    localparam int unsigned    CntW   = $clog2(CLKS_PER_BIT);
    localparam logic [CntW-1:0] CntMax = CntW'(CLKS_PER_BIT - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    assign bit_tick_o = en_i && (cnt_q == CntMax);

    always_comb begin
        cnt_d = '0;
        // Wrap to zero on the bit boundary and whenever the counter is idle.
        if (en_i && !bit_tick_o) begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: sends start bit, 8 data bits LSB first, optional parity and
// 1 or 2 stop bits. All outputs are registered; each output register is loaded
// with the value belonging to the state being entered.
// Ports:
//   clk        - system clock, rising edge
//   rst_n      - synchronous active-low reset
//   tx_start_i - send request, sampled only while idle
//   data_i     - byte to send, captured on the accepting edge
//   tx_o       - serial line, idle high
//   tx_busy_o  - high from the cycle after acceptance until the frame completes
//   tx_done_o  - one-cycle pulse in the first idle cycle after the frame
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DefaultClksPerBit,
    parameter int unsigned PARITY_EN    = 0,
    parameter int unsigned PARITY_ODD   = 0,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tx_start_i,
    input  logic [7:0] data_i,
    output logic       tx_o,
    output logic       tx_busy_o,
    output logic       tx_done_o
);

    localparam logic       OddParity = (PARITY_ODD != 0);
    localparam logic [2:0] LastStop  = 3'(STOP_BITS - 1);
    localparam logic [2:0] LastData  = 3'(DataBits - 1);

    uart_state_e state_q, state_d;
    logic [7:0]  shift_q, shift_d;
    logic [2:0]  idx_q, idx_d;     // data bit index, reused as stop bit index
    logic        par_q, par_d;
    logic        tx_q, tx_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        bit_tick;

    uart_baud_cnt #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_cnt (
        .clk       (clk),
        .rst_n     (rst_n),
        .en_i      (state_q != StIdle),
        .bit_tick_o(bit_tick)
    );

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        idx_d   = idx_q;
        par_d   = par_q;
        done_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (tx_start_i) begin
                    shift_d = data_i;
                    par_d   = calc_parity(data_i, OddParity);
                    state_d = StStart;
                end
            end
            StStart: begin
                if (bit_tick) begin
                    idx_d   = '0;
                    state_d = StData;
                end
            end
            StData: begin
                if (bit_tick) begin
                    if (idx_q == LastData) begin
                        idx_d   = '0;
                        state_d = (PARITY_EN != 0) ? StParity : StStop;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        // Current bit always sits in shift_q[0].
                        shift_d = shift_q >> 1;
                    end
                end
            end
            StParity: begin
                if (bit_tick) begin
                    idx_d   = '0;
                    state_d = StStop;
                end
            end
            StStop: begin
                if (bit_tick) begin
                    if (idx_q == LastStop) begin
                        idx_d   = '0;
                        done_d  = 1'b1;
                        state_d = StIdle;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // Line level for the state being entered keeps tx_o purely registered.
        unique case (state_d)
            StIdle:   tx_d = IdleLevel;
            StStart:  tx_d = StartBitLevel;
            StData:   tx_d = shift_d[0];
            StParity: tx_d = par_d;
            StStop:   tx_d = StopBitLevel;
            default:  tx_d = IdleLevel;
        endcase

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            shift_q <= '0;
            idx_q   <= '0;
            par_q   <= 1'b0;
            tx_q    <= IdleLevel;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign tx_o      = tx_q;
    assign tx_busy_o = busy_q;
    assign tx_done_o = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx. Three instances (no parity / 1 stop,
// even parity / 1 stop, odd parity / 2 stops) share one stimulus stream.
// A per-instance model queues the byte and acceptance cycle of every frame it
// expects; a per-instance monitor decodes the serial line and pops on completion.
module tb_uart_tx;

    localparam int unsigned C = 10;

    typedef struct {
        logic [7:0] b;
        int         acc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tx_start;
    logic [7:0] data;

    int  errors = 0;
    int  checks = 0;
    int  cyc = 0;
    bit  rst_at_edge = 1'b0;
    bit  seen_rst = 1'b0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc         <= cyc + 1;
        rst_at_edge <= !rst_n;
        if (!rst_n) seen_rst <= 1'b1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int unsigned PE = (g != 0) ? 1 : 0;
        localparam int unsigned PO = (g == 2) ? 1 : 0;
        localparam int unsigned SB = (g == 2) ? 2 : 1;
        localparam int unsigned NB = 10 + PE + SB - 1;   // bit periods per frame
        localparam int unsigned L  = NB * C;             // fall to done, in cycles

        logic tx, busy, done;
        exp_t exp_q[$];
        bit   in_frame = 1'b0;

        uart_tx #(
            .CLKS_PER_BIT(C),
            .PARITY_EN   (PE),
            .PARITY_ODD  (PO),
            .STOP_BITS   (SB)
        ) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .tx_start_i(tx_start),
            .data_i    (data),
            .tx_o      (tx),
            .tx_busy_o (busy),
            .tx_done_o (done)
        );

        function automatic string nm(input string s);
            return $sformatf("dut%0d_%s", g, s);
        endfunction

        // Model: a request is taken only when no frame is in flight; a frame
        // occupies L cycles after its acceptance edge.
        initial begin : model
            int rem;
            exp_t e;
            rem = 0;
            forever begin
                @(posedge clk);
                if (!rst_n) begin
                    rem = 0;
                    exp_q.delete();
                end else if (rem > 0) begin
                    rem--;
                end else if (tx_start) begin
                    e.b   = data;
                    e.acc = cyc;
                    exp_q.push_back(e);
                    rem = L;
                end
            end
        end

        // Monitor: decode the line on the falling clock edge.
        initial begin : mon
            int         rel, bp, fall_cyc;
            logic       bits [0:11];
            logic [7:0] got;
            exp_t       e;
            rel = 0;
            fall_cyc = 0;
            forever begin
                @(negedge clk);
                if (seen_rst) begin
                    if (rst_at_edge) begin
                        in_frame = 1'b0;
                        check(nm("rst_tx"), 32'(tx), 32'd1);
                        check(nm("rst_busy"), 32'(busy), 32'd0);
                        check(nm("rst_done"), 32'(done), 32'd0);
                    end else if (!in_frame) begin
                        check(nm("idle_done"), 32'(done), 32'd0);
                        if (tx === 1'b0) begin
                            in_frame = 1'b1;
                            rel      = 0;
                            fall_cyc = cyc;
                            bits[0]  = 1'b0;
                            check(nm("start_busy"), 32'(busy), 32'd1);
                        end else begin
                            check(nm("idle_tx"), 32'(tx), 32'd1);
                            check(nm("idle_busy"), 32'(busy), 32'd0);
                        end
                    end else begin
                        rel++;
                        if (rel < int'(L)) begin
                            bp = rel / int'(C);
                            if (rel % int'(C) == 0) bits[bp] = tx;
                            else check(nm("bit_stable"), 32'(tx), 32'(bits[bp]));
                            check(nm("frame_busy"), 32'(busy), 32'd1);
                            check(nm("frame_done"), 32'(done), 32'd0);
                        end else begin
                            in_frame = 1'b0;
                            check(nm("end_done"), 32'(done), 32'd1);
                            check(nm("end_busy"), 32'(busy), 32'd0);
                            check(nm("end_tx"), 32'(tx), 32'd1);
                            for (int i = 0; i < 8; i++) got[i] = bits[1 + i];
                            for (int s = 0; s < int'(SB); s++) begin
                                check(nm("stop_bit"), 32'(bits[9 + PE + s]), 32'd1);
                            end
                            if (exp_q.size() == 0) begin
                                check(nm("unexpected_frame"), 32'(got), 32'hFFFF_FFFF);
                            end else begin
                                e = exp_q.pop_front();
                                check(nm("data"), 32'(got), 32'(e.b));
                                check(nm("fall_time"), 32'(fall_cyc), 32'(e.acc + 1));
                                if (PE != 0) begin
                                    check(nm("parity"), 32'(bits[9]),
                                          32'((^e.b) ^ PO[0]));
                                end
                            end
                        end
                    end
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        data     = b;
        tx_start = 1'b1;
        idle(1);
        tx_start = 1'b0;
        data     = 8'($urandom);
    endtask

    initial begin
        rst_n    = 1'b0;
        tx_start = 1'b0;
        data     = 8'h00;
        idle(1);
        rst_n = 1'b1;
        idle(10);

        send(8'h55);
        idle(140);
        send(8'h07);
        idle(140);
        send(8'hA3);
        idle(140);

        // Held request: second frame must start right after each done cycle.
        data     = 8'h00;
        tx_start = 1'b1;
        idle(1);
        data = 8'hFF;
        idle(125);
        tx_start = 1'b0;
        idle(140);

        // Request during a frame is ignored; data changes have no effect.
        send(8'h3C);
        idle(30);
        send(8'h12);
        idle(140);

        // Reset during data bit 4 aborts the frame without a done pulse.
        send(8'hC5);
        idle(54);
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
        idle(10);
        send(8'h9E);
        idle(140);

        repeat (25) begin
            data     = 8'($urandom);
            tx_start = 1'b1;
            idle(int'($urandom_range(1, 3)));
            tx_start = 1'b0;
            data     = 8'($urandom);
            idle(int'($urandom_range(0, 130)));
        end

        idle(200);
        check("dut0_pending", 32'(g_dut[0].exp_q.size()), 32'd0);
        check("dut1_pending", 32'(g_dut[1].exp_q.size()), 32'd0);
        check("dut2_pending", 32'(g_dut[2].exp_q.size()), 32'd0);
        check("dut0_in_frame", 32'(g_dut[0].in_frame), 32'd0);
        check("dut1_in_frame", 32'(g_dut[1].in_frame), 32'd0);
        check("dut2_in_frame", 32'(g_dut[2].in_frame), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
